ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage.
- Selects forwarded operands, performs ALU operations, and runs an iterative 32-cycle MULT/MULTU unit with HI/LO registers.
- Registers the EX/MEM pipeline outputs: write-back control, memory write enable, ALU result (data address), store data and destination register.
- Asserts busy to stall upstream stages while a multiply is in progress.

---
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative shift-add MULT/MULTU
// with HI/LO, and the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wbi,
  input  logic        mi,
  input  logic [4:0]  regaddr_in,
  input  logic [3:0]  alu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] imm,
  input  logic        alusrc,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  output logic [1:0]  wbo,
  output logic        mo,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  regaddr_out,
  output logic        busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic { IDLE, MUL } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [1:0]  wb_q, wb_d;
  logic        m_q, m_d;
  logic [31:0] res_q, res_d, sd_q, sd_d;
  logic [4:0]  ra_q, ra_d;

  logic [31:0] op_a, fwd_b_val, op_b, alu_y;
  logic        is_mul, is_signed_mul;
  logic [31:0] mag_a, mag_b;
  logic [63:0] step_sum, prod_fin;

  // Forwarding muxes; store data is the forwarded B before the immediate mux
  always_comb begin
    unique case (fwd_a)
      2'b01:   op_a = fwd_mem;
      2'b10:   op_a = fwd_wb;
      default: op_a = rs_val;
    endcase
    unique case (fwd_b)
      2'b01:   fwd_b_val = fwd_mem;
      2'b10:   fwd_b_val = fwd_wb;
      default: fwd_b_val = rt_val;
    endcase
    op_b = alusrc ? imm : fwd_b_val;
  end

  // Single-cycle ALU; multiply opcodes produce nothing here
  always_comb begin
    alu_y = '0;
    case (alu_op)
      4'd0:  alu_y = op_a + op_b;
      4'd1:  alu_y = op_a - op_b;
      4'd2:  alu_y = op_a & op_b;
      4'd3:  alu_y = op_a | op_b;
      4'd4:  alu_y = op_a ^ op_b;
      4'd5:  alu_y = ~(op_a | op_b);
      4'd6:  alu_y = {31'b0, ($signed(op_a) < $signed(op_b))};
      4'd7:  alu_y = {31'b0, (op_a < op_b)};
      4'd8:  alu_y = op_b << op_a[4:0];
      4'd9:  alu_y = op_b >> op_a[4:0];
      4'd10: alu_y = $unsigned($signed(op_b) >>> op_a[4:0]);
      4'd11: alu_y = {op_b[15:0], 16'b0};
      4'd14: alu_y = hi_q;
      4'd15: alu_y = lo_q;
      default: alu_y = '0;
    endcase
  end

  // Multiplier operand prep: signed MULT works on magnitudes, sign fixed at the end
  assign is_mul        = (alu_op == 4'd12) || (alu_op == 4'd13);
  assign is_signed_mul = (alu_op == 4'd12);
  assign mag_a    = (is_signed_mul && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign mag_b    = (is_signed_mul && op_b[31]) ? (~op_b + 32'd1) : op_b;
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign prod_fin = neg_q ? (~step_sum + 64'd1) : step_sum;

  // Next-state: FSM, multiplier datapath and EX/MEM register contents
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    wb_d     = '0;
    m_d      = 1'b0;
    res_d    = '0;
    sd_d     = '0;
    ra_d     = '0;
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          mcand_d  = {32'b0, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed_mul & (op_a[31] ^ op_b[31]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end else begin
          wb_d  = wbi;
          m_d   = mi;
          res_d = alu_y;
          sd_d  = fwd_b_val;
          ra_d  = regaddr_in;
        end
      end
      MUL: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = prod_fin;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, HI/LO and EX/MEM register; reset discards any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      wb_q    <= '0;
      m_q     <= 1'b0;
      res_q   <= '0;
      sd_q    <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      wb_q    <= wb_d;
      m_q     <= m_d;
      res_q   <= res_d;
      sd_q    <= sd_d;
      ra_q    <= ra_d;
    end
  end

  // Shift-add datapath; always reloaded when a multiply is accepted
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign wbo         = wb_q;
  assign mo          = m_q;
  assign alu_result  = res_q;
  assign store_data  = sd_q;
  assign regaddr_out = ra_q;
  assign busy        = (state_q == MUL);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes the expected EX/MEM
// contents for every edge it drives; the monitor pops and compares after
// each edge.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wbi;
  logic        mi;
  logic [4:0]  regaddr_in;
  logic [3:0]  alu_op;
  logic [31:0] rs_val, rt_val, imm, fwd_mem, fwd_wb;
  logic        alusrc;
  logic [1:0]  fwd_a, fwd_b;
  logic [1:0]  wbo;
  logic        mo;
  logic [31:0] alu_result, store_data;
  logic [4:0]  regaddr_out;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .wbi(wbi), .mi(mi), .regaddr_in(regaddr_in),
    .alu_op(alu_op), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
    .alusrc(alusrc), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_mem(fwd_mem),
    .fwd_wb(fwd_wb), .wbo(wbo), .mo(mo), .alu_result(alu_result),
    .store_data(store_data), .regaddr_out(regaddr_out), .busy(busy)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  wbi;
    logic        mi;
    logic [4:0]  ra;
    logic [3:0]  op;
    logic [31:0] rs, rt, imm;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] fmem, fwb;
  } in_t;

  typedef struct {
    logic [1:0]  wbo;
    logic        mo;
    logic [31:0] res;
    logic [31:0] sd;
    logic        chk_sd;
    logic [4:0]  ra;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t sb[$];

  function automatic in_t rr(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] ra);
    in_t v;
    v = '0;
    v.wbi = 2'b10;
    v.ra  = ra;
    v.op  = op;
    v.rs  = a;
    v.rt  = b;
    return v;
  endfunction

  function automatic exp_t ex(input logic [1:0] w, input logic m,
                              input logic [31:0] r, input logic [31:0] s,
                              input logic [4:0] ra, input string tag);
    exp_t e;
    e.wbo = w; e.mo = m; e.res = r; e.sd = s; e.chk_sd = 1'b1;
    e.ra = ra; e.busy = 1'b0; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t bub(input logic b, input string tag);
    exp_t e;
    e = ex(2'b00, 1'b0, 32'h0, 32'h0, 5'd0, tag);
    e.chk_sd = 1'b0;
    e.busy = b;
    return e;
  endfunction

  task automatic issue(input in_t v, input exp_t e);
    @(negedge clk);
    reset = v.rst; wbi = v.wbi; mi = v.mi; regaddr_in = v.ra; alu_op = v.op;
    rs_val = v.rs; rt_val = v.rt; imm = v.imm; alusrc = v.alusrc;
    fwd_a = v.fa; fwd_b = v.fb; fwd_mem = v.fmem; fwd_wb = v.fwb;
    sb.push_back(e);
  endtask

  // Multiply accepted, 32 busy edges, then one bubble edge with busy low;
  // "held" is what upstream keeps presenting while stalled
  task automatic mul_seq(input in_t m, input in_t held, input string tag);
    issue(m, bub(1'b1, {tag, "_accept"}));
    repeat (31) issue(held, bub(1'b1, {tag, "_busy"}));
    issue(held, bub(1'b0, {tag, "_done"}));
  endtask

  // Monitor: one expected entry per driven edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (wbo !== e.wbo || mo !== e.mo || alu_result !== e.res ||
            regaddr_out !== e.ra || busy !== e.busy ||
            (e.chk_sd && store_data !== e.sd)) begin
          failures++;
          $display("FAIL %s: got wbo=%h mo=%b res=%h sd=%h ra=%0d busy=%b, want wbo=%h mo=%b res=%h sd=%h(chk=%b) ra=%0d busy=%b",
                   e.tag, wbo, mo, alu_result, store_data, regaddr_out, busy,
                   e.wbo, e.mo, e.res, e.sd, e.chk_sd, e.ra, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    int  wait_cyc;
    reset = 1'b1; wbi = '0; mi = 1'b0; regaddr_in = '0; alu_op = '0;
    rs_val = '0; rt_val = '0; imm = '0; alusrc = 1'b0; fwd_a = '0;
    fwd_b = '0; fwd_mem = '0; fwd_wb = '0;

    // Reset with nonzero inputs
    v = rr(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    v.rst = 1'b1; v.wbi = 2'b11; v.mi = 1'b1;
    issue(v, ex(2'b00, 1'b0, 32'h0, 32'h0, 5'd0, "reset"));
    issue(v, ex(2'b00, 1'b0, 32'h0, 32'h0, 5'd0, "reset_hold"));
    issue(rr(4'd15, 32'h0, 32'h0, 5'd3), ex(2'b10, 1'b0, 32'h0, 32'h0, 5'd3, "mflo_after_reset"));
    issue(rr(4'd14, 32'h0, 32'h0, 5'd4), ex(2'b10, 1'b0, 32'h0, 32'h0, 5'd4, "mfhi_after_reset"));

    // ALU basics
    issue(rr(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd1), ex(2'b10, 1'b0, 32'h8000_0000, 32'h1, 5'd1, "add_wrap"));
    issue(rr(4'd6, 32'hFFFF_FFFF, 32'h1, 5'd2), ex(2'b10, 1'b0, 32'h1, 32'h1, 5'd2, "slt"));
    issue(rr(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd3), ex(2'b10, 1'b0, 32'h0, 32'h1, 5'd3, "sltu"));
    issue(rr(4'd5, 32'h0, 32'h0, 5'd4), ex(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd4, "nor"));
    issue(rr(4'd10, 32'd4, 32'h8000_0000, 5'd5), ex(2'b10, 1'b0, 32'hF800_0000, 32'h8000_0000, 5'd5, "sra"));
    issue(rr(4'd9, 32'd4, 32'h8000_0000, 5'd6), ex(2'b10, 1'b0, 32'h0800_0000, 32'h8000_0000, 5'd6, "srl"));
    issue(rr(4'd8, 32'd31, 32'h3, 5'd7), ex(2'b10, 1'b0, 32'h8000_0000, 32'h3, 5'd7, "sll"));
    v = rr(4'd11, 32'h0, 32'h55, 5'd8); v.alusrc = 1'b1; v.imm = 32'h0000_1234;
    issue(v, ex(2'b10, 1'b0, 32'h1234_0000, 32'h55, 5'd8, "lui"));

    // Forwarding
    v = rr(4'd1, 32'h1, 32'h2, 5'd9); v.fa = 2'b01; v.fmem = 32'h10; v.fb = 2'b10; v.fwb = 32'h20;
    issue(v, ex(2'b10, 1'b0, 32'hFFFF_FFF0, 32'h20, 5'd9, "sub_fwd"));
    v = rr(4'd0, 32'h100, 32'h5, 5'd0); v.wbi = 2'b00; v.mi = 1'b1; v.alusrc = 1'b1;
    v.imm = 32'd4; v.fb = 2'b01; v.fmem = 32'hDEAD_BEEF;
    issue(v, ex(2'b00, 1'b1, 32'h104, 32'hDEAD_BEEF, 5'd0, "store"));
    v = rr(4'd4, 32'h1, 32'h2, 5'd10); v.fa = 2'b11; v.fb = 2'b11;
    issue(v, ex(2'b10, 1'b0, 32'h3, 32'h2, 5'd10, "fwd_11_regs"));

    // Bubble input still registers the ALU result
    v = rr(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd11); v.wbi = 2'b00;
    issue(v, ex(2'b00, 1'b0, 32'h0000_F000, 32'h0000_FF00, 5'd11, "bubble_and"));

    // Signed MULT -2 * 3, MFLO held during busy
    mul_seq(rr(4'd12, 32'hFFFF_FFFE, 32'h3, 5'd0), rr(4'd15, 32'h0, 32'h0, 5'd12), "mult_neg");
    issue(rr(4'd15, 32'h0, 32'h0, 5'd12), ex(2'b10, 1'b0, 32'hFFFF_FFFA, 32'h0, 5'd12, "mflo_mult"));
    issue(rr(4'd14, 32'h0, 32'h0, 5'd13), ex(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd13, "mfhi_mult"));

    // Back-to-back: MULT 7 * -5 then MULTU held and accepted in cycle 33
    mul_seq(rr(4'd12, 32'd7, 32'hFFFF_FFFB, 5'd0), rr(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0), "mult_b2b");
    mul_seq(rr(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0), rr(4'd14, 32'h0, 32'h0, 5'd14), "multu");
    issue(rr(4'd14, 32'h0, 32'h0, 5'd14), ex(2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 5'd14, "mfhi_multu"));
    issue(rr(4'd15, 32'h0, 32'h0, 5'd15), ex(2'b10, 1'b0, 32'h0000_0001, 32'h0, 5'd15, "mflo_multu"));

    // Reset at busy cycle 10 of a MULT
    issue(rr(4'd12, 32'd5, 32'd7, 5'd0), bub(1'b1, "rstmul_accept"));
    repeat (9) issue(rr(4'd0, 32'h1, 32'h1, 5'd1), bub(1'b1, "rstmul_busy"));
    v = rr(4'd0, 32'h1, 32'h1, 5'd1); v.rst = 1'b1;
    issue(v, ex(2'b00, 1'b0, 32'h0, 32'h0, 5'd0, "rstmul_reset"));
    issue(rr(4'd14, 32'h0, 32'h0, 5'd16), ex(2'b10, 1'b0, 32'h0, 32'h0, 5'd16, "mfhi_after_rstmul"));
    issue(rr(4'd15, 32'h0, 32'h0, 5'd17), ex(2'b10, 1'b0, 32'h0, 32'h0, 5'd17, "mflo_after_rstmul"));
    issue(rr(4'd0, 32'd40, 32'd2, 5'd18), ex(2'b10, 1'b0, 32'd42, 32'd2, 5'd18, "add_after_rstmul"));

    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
